// File: rtl/runway_pattern_decoder.sv
// Runway-light pattern decoder: watches the 3-bit light pattern, recovers the
// wind code behind each transition, flags ambiguous or illegal samples and
// reports a locked wind after CONFIRM identical decodes in a row.
module runway_pattern_decoder #(
    parameter int CONFIRM = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [2:0]       i_lights,
    input  logic             i_clr_fault,
    output logic [1:0]       o_wind,
    output logic             o_locked,
    output logic             o_ambig,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int RUN_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CONFIRM);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    localparam logic [2:0] P_101 = 3'b101;
    localparam logic [2:0] P_001 = 3'b001;
    localparam logic [2:0] P_010 = 3'b010;
    localparam logic [2:0] P_100 = 3'b100;

    typedef enum logic [1:0] {S_EMPTY, S_TRACK, S_LOCKED, S_FAULT} state_t;

    state_t             r_state, w_state_next;
    logic [2:0]         r_prev, w_prev_next;
    logic [1:0]         r_wind, w_wind_next;
    logic               r_locked, w_locked_next;
    logic               r_ambig, w_ambig_next;
    logic               r_fault, w_fault_next;
    logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_next;
    logic [RUN_W-1:0]   r_run, w_run_next;

    logic               w_pat_bad;
    logic               w_trans_bad;
    logic               w_trans_ambig;
    logic               w_illegal;
    logic [1:0]         w_code;
    logic [RUN_W-1:0]   w_run_new;
    logic [CNT_W-1:0]   w_err_inc;

    // Transition decode: classify the current pattern against the previous one.
    always_comb begin
        w_pat_bad     = !((i_lights == P_101) || (i_lights == P_001) ||
                          (i_lights == P_010) || (i_lights == P_100));
        w_trans_bad   = (r_prev == P_100) && (i_lights == P_101);
        w_trans_ambig = (r_prev == P_100) && (i_lights == P_010);
        w_code        = 2'b11;  // repeating the same pattern always means 11
        case (r_prev)
            P_101: begin
                if (i_lights == P_010)      w_code = 2'b00;
                else if (i_lights == P_001) w_code = 2'b01;
                else if (i_lights == P_100) w_code = 2'b10;
            end
            P_001: begin
                if (i_lights == P_101)      w_code = 2'b00;
                else if (i_lights == P_010) w_code = 2'b01;
                else if (i_lights == P_100) w_code = 2'b10;
            end
            P_010: begin
                if (i_lights == P_101)      w_code = 2'b00;
                else if (i_lights == P_100) w_code = 2'b01;
                else if (i_lights == P_001) w_code = 2'b10;
            end
            default: begin
                if (i_lights == P_001)      w_code = 2'b01;
            end
        endcase
        // A stale prev in EMPTY/FAULT must not turn a legal pattern illegal.
        w_illegal = w_pat_bad ||
                    (((r_state == S_TRACK) || (r_state == S_LOCKED)) && w_trans_bad);
        w_run_new = (w_code == r_wind) ?
                    ((r_run >= RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1)) : RUN_W'(1);
        w_err_inc = (r_err_cnt == ERR_MAX) ? r_err_cnt : r_err_cnt + CNT_W'(1);
    end

    // Next-state and next-output logic; everything holds unless a sample or clear acts.
    always_comb begin
        w_state_next   = r_state;
        w_prev_next    = r_prev;
        w_wind_next    = r_wind;
        w_locked_next  = r_locked;
        w_ambig_next   = r_ambig;
        w_fault_next   = r_fault;
        w_err_cnt_next = r_err_cnt;
        w_run_next     = r_run;
        if (i_clr_fault && (r_state == S_FAULT)) begin
            // Clearing wins over any sample taken in the same cycle.
            w_state_next = S_EMPTY;
            w_fault_next = 1'b0;
        end else if (i_en) begin
            if (w_illegal) begin
                w_state_next   = S_FAULT;
                w_fault_next   = 1'b1;
                w_err_cnt_next = w_err_inc;
                w_locked_next  = 1'b0;
                w_run_next     = '0;
                w_ambig_next   = 1'b0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        w_prev_next  = i_lights;
                        w_state_next = S_TRACK;
                    end
                    S_TRACK, S_LOCKED: begin
                        w_prev_next = i_lights;
                        if (w_trans_ambig) begin
                            w_ambig_next = 1'b1;
                        end else begin
                            w_wind_next   = w_code;
                            w_ambig_next  = 1'b0;
                            w_run_next    = w_run_new;
                            w_locked_next = (w_run_new == RUN_MAX);
                            w_state_next  = (w_run_new == RUN_MAX) ? S_LOCKED : S_TRACK;
                        end
                    end
                    default: begin
                        // FAULT: legal samples are ignored until cleared.
                    end
                endcase
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_EMPTY;
            r_prev    <= P_101;
            r_wind    <= 2'b00;
            r_locked  <= 1'b0;
            r_ambig   <= 1'b0;
            r_fault   <= 1'b0;
            r_err_cnt <= '0;
            r_run     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_prev    <= w_prev_next;
            r_wind    <= w_wind_next;
            r_locked  <= w_locked_next;
            r_ambig   <= w_ambig_next;
            r_fault   <= w_fault_next;
            r_err_cnt <= w_err_cnt_next;
            r_run     <= w_run_next;
        end
    end

    assign o_wind    = r_wind;
    assign o_locked  = r_locked;
    assign o_ambig   = r_ambig;
    assign o_fault   = r_fault;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_runway_pattern_decoder.sv
// Scoreboard bench for runway_pattern_decoder: stimulus pushes the expected
// outputs for each cycle; a monitor pops and compares after each rising edge.
module tb_runway_pattern_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] lights = 3'b000;
    logic       clr_fault = 1'b0;
    logic [1:0] wind;
    logic       locked, ambig, fault;
    logic [3:0] err_cnt;

    logic [8:0] exp_q[$];
    logic       obs = 1'b0;
    int         checks = 0;
    int         errors = 0;

    runway_pattern_decoder #(.CONFIRM(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .i_en(en), .i_lights(lights),
        .i_clr_fault(clr_fault), .o_wind(wind), .o_locked(locked),
        .o_ambig(ambig), .o_fault(fault), .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and record what the outputs must be after the edge.
    task automatic step(input logic rst, input logic e, input logic [2:0] l, input logic c,
                        input logic [1:0] ew, input logic el, input logic ea,
                        input logic ef, input logic [3:0] ee);
        @(negedge clk);
        reset = rst; en = e; lights = l; clr_fault = c;
        exp_q.push_back({ew, el, ea, ef, ee});
        obs = 1'b1;
    endtask

    // Monitor: compare outputs against the scoreboard just after each observed edge.
    always @(posedge clk) begin
        if (obs) begin
            logic [8:0] e_v;
            logic [8:0] a_v;
            #1;
            checks++;
            a_v = {wind, locked, ambig, fault, err_cnt};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got wind=%b locked=%b ambig=%b fault=%b err=%0d",
                         wind, locked, ambig, fault, err_cnt);
            end else begin
                e_v = exp_q.pop_front();
                if (a_v !== e_v)
                    begin
                        errors++;
                        $display("FAIL outputs @%0t: got wind=%b locked=%b ambig=%b fault=%b err=%0d, want wind=%b locked=%b ambig=%b fault=%b err=%0d",
                                 $time, a_v[8:7], a_v[6], a_v[5], a_v[4], a_v[3:0],
                                 e_v[8:7], e_v[6], e_v[5], e_v[4], e_v[3:0]);
                    end
                else
                    $display("ok @%0t wind=%b locked=%b ambig=%b fault=%b err=%0d",
                             $time, wind, locked, ambig, fault, err_cnt);
            end
        end
    end

    logic [2:0] bad_pats[4] = '{3'b000, 3'b011, 3'b110, 3'b111};

    initial begin
        // Reset, with a sample presented that reset must override.
        step(1, 1, 3'b011, 0, 2'b00, 0, 0, 0, 4'd0);
        step(1, 0, 3'b000, 0, 2'b00, 0, 0, 0, 4'd0);

        // Calm wind: 101,010,101,010 locks on the 4th sample.
        step(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b00, 1, 0, 0, 4'd0);

        // Wind 01, then a change to 10 drops lock.
        step(1, 0, 3'b000, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b001, 0, 2'b01, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b01, 0, 0, 0, 4'd0);
        step(0, 1, 3'b100, 0, 2'b01, 1, 0, 0, 4'd0);
        step(0, 1, 3'b001, 0, 2'b01, 1, 0, 0, 4'd0);
        step(0, 1, 3'b100, 0, 2'b10, 0, 0, 0, 4'd0);

        // Ambiguity holds wind and run: run stays 1, so two more 10s are needed to lock.
        step(1, 0, 3'b000, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b001, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b100, 0, 2'b10, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b10, 0, 1, 0, 4'd0);
        step(0, 1, 3'b001, 0, 2'b10, 0, 0, 0, 4'd0);
        step(0, 1, 3'b100, 0, 2'b10, 1, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b10, 1, 1, 0, 4'd0);

        // Illegal pattern while locked, ignored legal sample, clear with a discarded sample.
        step(0, 1, 3'b011, 0, 2'b10, 0, 0, 1, 4'd1);
        step(0, 1, 3'b101, 0, 2'b10, 0, 0, 1, 4'd1);
        step(0, 0, 3'b101, 0, 2'b10, 0, 0, 1, 4'd1);
        step(0, 1, 3'b011, 1, 2'b10, 0, 0, 0, 4'd1);
        step(0, 1, 3'b101, 0, 2'b10, 0, 0, 0, 4'd1);
        step(0, 1, 3'b010, 0, 2'b00, 0, 0, 0, 4'd1);
        // clr_fault outside FAULT is ignored; sample 010->101 decodes 00.
        step(0, 1, 3'b101, 1, 2'b00, 0, 0, 0, 4'd1);

        // Illegal transition 100->101, then saturation of the error counter.
        step(0, 1, 3'b100, 0, 2'b10, 0, 0, 0, 4'd1);
        step(0, 1, 3'b101, 0, 2'b10, 0, 0, 1, 4'd2);
        for (int k = 0; k < 16; k++) begin
            int ev;
            ev = (3 + k > 15) ? 15 : 3 + k;
            step(0, 1, bad_pats[k % 4], 0, 2'b10, 0, 0, 1, 4'(ev));
        end

        // en gaps: garbage on idle cycles must not be sampled.
        step(1, 0, 3'b000, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 0, 3'b111, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 0, 3'b011, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 0, 3'b110, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b00, 1, 0, 0, 4'd0);

        // Reset while locked, then the first sample only primes prev.
        step(1, 1, 3'b101, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b010, 0, 2'b00, 0, 0, 0, 4'd0);
        step(0, 1, 3'b100, 0, 2'b01, 0, 0, 0, 4'd0);

        @(negedge clk);
        obs = 1'b0;
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/runway_pattern_decoder.md
Name: runway_pattern_decoder

Overview:
Observer at the receiving end of the runway-light interface. Samples the 3-bit light pattern driven by the runway lights FSM and recovers the wind code (w1,w0) that produced each transition. Flags ambiguous transitions and illegal patterns or transitions. Reports a "locked" wind once the decoded code has been stable for a configurable number of samples. Sits beside the lights driver as a self-check and telemetry block.

Parameters:
CONFIRM, 3, consecutive identical decodes required to assert locked (legal range >=1)
CNT_W, 4, width of the saturating illegal-event counter err_cnt

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; overrides every other input
en  input  1  sample strobe; lights is sampled only on cycles with en=1
lights  input  3  light pattern; legal values are 101, 001, 010, 100
clr_fault  input  1  leaves FAULT and returns to EMPTY
wind  output  2  last decoded wind code {w1,w0}
locked  output  1  wind has been decoded identically CONFIRM consecutive times
ambig  output  1  last sample was an ambiguous transition
fault  output  1  sticky illegal-event flag
err_cnt  output  CNT_W  saturating count of illegal samples

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: state=EMPTY, wind=00, locked=0, ambig=0, fault=0, err_cnt=0, run=0. Internal prev pattern register is a don't-care.
- All outputs are registered. Outputs reflect a sample taken with en=1 at edge N after edge N, i.e. one cycle of latency.
- When en=0 and clr_fault=0, nothing changes.
- Decode table, prev->cur : wind:
  - from 101: 010:00, 001:01, 100:10, 101:11
  - from 001: 101:00, 010:01, 100:10, 001:11
  - from 010: 101:00, 100:01, 001:10, 010:11
  - from 100: 001:01, 100:11, 010:AMBIGUOUS (00 or 10), 101:ILLEGAL
- Illegal sample: cur is 000, 011, 110 or 111, or the transition is 100->101.
- State EMPTY (no previous sample):
  - en with a legal pattern: prev<=lights, go to TRACK. No decode; wind, ambig and locked are unchanged.
  - en with an illegal pattern: handle as an illegal event.
- States TRACK and LOCKED, on en:
  - Unambiguous legal transition: wind<=code, ambig<=0. If code equals the current wind, run<=min(run+1, CONFIRM); otherwise run<=1. locked<=(new run==CONFIRM). State is LOCKED when locked=1, else TRACK.
  - Ambiguous transition: ambig<=1. wind, run and locked are held.
  - prev<=lights after every legal sample.
- Illegal event, in any state:
  - fault<=1, err_cnt<=err_cnt+1 (saturating at 2^CNT_W-1), locked<=0, run<=0, wind held, ambig<=0.
  - Go to FAULT.
- State FAULT:
  - Decoding is suspended.
  - Further illegal samples still increment err_cnt. Legal samples are ignored.
- clr_fault:
  - In FAULT: go to EMPTY and set fault<=0. err_cnt is retained and is cleared only by reset.
  - clr_fault has priority over a sample taken in the same cycle; that sample is discarded.
  - Outside FAULT, clr_fault is ignored and the sample is processed normally.
- The run counter is wide enough to hold CONFIRM and saturates at CONFIRM.
- Reset mid-operation (including in LOCKED or FAULT) returns to the reset values on the next edge.

Test Plan:
- Calm wind, CONFIRM=3, en=1: lights 101,010,101,010 -> after 4th sample wind=00, locked=1, ambig=0, fault=0. After 3rd sample locked=0.
- Wind 01: lights 101,001,010,100,001 -> wind=01 from the 2nd sample on, locked=1 after 4th sample and still 1 after 5th. Then lights 100 (code 10) -> wind=10, locked=0.
- Ambiguity: lights 001,100,010 -> after 2nd sample wind=10, ambig=0. After 3rd sample ambig=1, wind=10, run unchanged.
- Illegal pattern 011 while locked -> next edge fault=1, err_cnt=1, locked=0. Then lights 101 -> no change. Then clr_fault=1 -> fault=0, state EMPTY. Then lights 101,010 -> wind=00.
- Illegal transition 100->101 -> fault=1, err_cnt increments. Then 16 further illegal samples with CNT_W=4 -> err_cnt saturates at 15.
- en gaps and reset: samples separated by en=0 cycles decode identically to back-to-back samples. Reset asserted in LOCKED -> next edge wind=00, locked=0, err_cnt=0, state EMPTY.
